// File: rtl/param_update_arbiter.sv
// param_update_arbiter: owns the live tone settings (phaseinc, gain).
// Arbitrates preset / encoder / sweep requests, applies clamped updates and
// offers each result to the DDS/gain stage over a valid/ready handshake.
module param_update_arbiter #(
  parameter logic [14:0] MIDFREQ     = 15'd1048,
  parameter logic [8:0]  DEFAULTGAIN = 9'd32,
  parameter logic [14:0] MININC      = 15'd21,
  parameter logic [14:0] MAXINC      = 15'd20971,
  parameter logic [8:0]  GAINMAX     = 9'd255,
  parameter logic [14:0] SWEEP_STEP  = 15'd64,
  parameter logic [15:0] TIMEOUT     = 16'd50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enc_step,
  input  logic        enc_dir,
  input  logic        enc_mode,
  input  logic        sweep_en,
  input  logic        sweep_tick,
  input  logic        preset_load,
  input  logic [14:0] preset_phaseinc,
  input  logic [8:0]  preset_gain,
  input  logic        upd_ready,
  output logic [14:0] phaseinc,
  output logic [8:0]  gain,
  output logic        upd_valid,
  output logic        busy,
  output logic        overrun
);

  localparam int unsigned PW = 15;
  localparam int unsigned GW = 9;
  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_OFFER = 2'd2
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_phaseinc;
  logic [GW-1:0]   r_gain;
  logic            r_upd_valid;
  logic            r_busy;
  logic            r_overrun;
  logic [CW-1:0]   r_cnt;

  // pending request slots
  logic            r_pre_full;
  logic [PW-1:0]   r_pre_inc;
  logic [GW-1:0]   r_pre_gain;
  logic            r_enc_full;
  logic            r_enc_dir;
  logic            r_enc_mode;
  logic            r_sweep_full;

  logic            w_sweep_req;
  logic            w_any_req;
  logic            w_sel_pre;
  logic            w_sel_enc;
  logic            w_sel_sweep;
  logic            w_serve;
  logic            w_drop;
  logic [PW-1:0]   w_pre_inc;
  logic [GW-1:0]   w_pre_gain;
  logic [PW-1:0]   w_enc_inc;
  logic [GW-1:0]   w_enc_gain;
  logic [CW-1:0]   w_sweep_sum;
  logic [PW-1:0]   w_sweep_inc;
  logic [PW-1:0]   w_new_inc;
  logic [GW-1:0]   w_new_gain;

  assign phaseinc  = r_phaseinc;
  assign gain      = r_gain;
  assign upd_valid = r_upd_valid;
  assign busy      = r_busy;
  assign overrun   = r_overrun;

  // Request selection and candidate update values
  always_comb begin
    w_sweep_req = sweep_tick & sweep_en;
    // incoming pulses count so IDLE reaches APPLY in the same cycle the slot fills
    w_any_req   = r_pre_full | r_enc_full | r_sweep_full |
                  preset_load | enc_step | w_sweep_req;

    w_sel_pre   = (r_state == ST_APPLY) & r_pre_full;
    w_sel_enc   = (r_state == ST_APPLY) & ~r_pre_full & r_enc_full;
    w_sel_sweep = (r_state == ST_APPLY) & ~r_pre_full & ~r_enc_full & r_sweep_full;
    w_serve     = w_sel_pre | w_sel_enc | w_sel_sweep;

    w_drop = (preset_load & r_pre_full & ~w_sel_pre) |
             (enc_step & r_enc_full & ~w_sel_enc) |
             (w_sweep_req & r_sweep_full & ~w_sel_sweep);

    // preset: clamp both fields into the legal range
    if (r_pre_inc < MININC) begin
      w_pre_inc = MININC;
    end else if (r_pre_inc > MAXINC) begin
      w_pre_inc = MAXINC;
    end else begin
      w_pre_inc = r_pre_inc;
    end
    w_pre_gain = (r_pre_gain > GAINMAX) ? GAINMAX : r_pre_gain;

    // encoder: single-step, saturating at the legal limits
    w_enc_inc  = r_phaseinc;
    w_enc_gain = r_gain;
    if (!r_enc_mode) begin
      if (r_enc_dir) begin
        w_enc_inc = (r_phaseinc >= MAXINC) ? MAXINC : r_phaseinc + PW'(1);
      end else begin
        w_enc_inc = (r_phaseinc <= MININC) ? MININC : r_phaseinc - PW'(1);
      end
    end else begin
      if (r_enc_dir) begin
        w_enc_gain = (r_gain >= GAINMAX) ? GAINMAX : r_gain + GW'(1);
      end else begin
        w_enc_gain = (r_gain == GW'(0)) ? GW'(0) : r_gain - GW'(1);
      end
    end

    // sweep: 16-bit sum, wraps back to the bottom of the range past MAXINC
    w_sweep_sum = CW'(r_phaseinc) + CW'(SWEEP_STEP);
    w_sweep_inc = (w_sweep_sum > CW'(MAXINC)) ? MININC : w_sweep_sum[PW-1:0];

    w_new_inc  = r_phaseinc;
    w_new_gain = r_gain;
    if (w_sel_pre) begin
      w_new_inc  = w_pre_inc;
      w_new_gain = w_pre_gain;
    end else if (w_sel_enc) begin
      w_new_inc  = w_enc_inc;
      w_new_gain = w_enc_gain;
    end else if (w_sel_sweep) begin
      w_new_inc  = w_sweep_inc;
    end
  end

  // Pending slots: consume in APPLY, refill on pulse, flag drops as overrun
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pre_full   <= 1'b0;
      r_pre_inc    <= '0;
      r_pre_gain   <= '0;
      r_enc_full   <= 1'b0;
      r_enc_dir    <= 1'b0;
      r_enc_mode   <= 1'b0;
      r_sweep_full <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_sel_pre) begin
        r_pre_full <= 1'b0;
      end
      if (preset_load && (!r_pre_full || w_sel_pre)) begin
        r_pre_full <= 1'b1;
        r_pre_inc  <= preset_phaseinc;
        r_pre_gain <= preset_gain;
      end

      if (w_sel_enc) begin
        r_enc_full <= 1'b0;
      end
      if (enc_step && (!r_enc_full || w_sel_enc)) begin
        r_enc_full <= 1'b1;
        r_enc_dir  <= enc_dir;
        r_enc_mode <= enc_mode;
      end

      if (!sweep_en) begin
        r_sweep_full <= 1'b0;
      end else begin
        if (w_sel_sweep) begin
          r_sweep_full <= 1'b0;
        end
        if (w_sweep_req && (!r_sweep_full || w_sel_sweep)) begin
          r_sweep_full <= 1'b1;
        end
      end

      if (w_drop) begin
        r_overrun <= 1'b1;
      end
    end
  end

  // Control FSM: IDLE -> APPLY (one cycle) -> OFFER until ready or timeout
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_phaseinc  <= MIDFREQ;
      r_gain      <= DEFAULTGAIN;
      r_upd_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_state <= ST_APPLY;
            r_busy  <= 1'b1;
          end
        end
        ST_APPLY: begin
          if (w_serve) begin
            r_phaseinc  <= w_new_inc;
            r_gain      <= w_new_gain;
            r_upd_valid <= 1'b1;
            r_cnt       <= '0;
            r_state     <= ST_OFFER;
          end else begin
            // sweep request withdrawn by sweep_en falling; nothing to serve
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_OFFER: begin
          if (upd_ready || (r_cnt == TIMEOUT - CW'(1))) begin
            r_upd_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_upd_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_update_arbiter.sv
// Scoreboard bench for param_update_arbiter: stimulus pushes expected offers,
// a negedge monitor pops and compares on each new upd_valid assertion.
module tb_param_update_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enc_step, enc_dir, enc_mode;
  logic        sweep_en, sweep_tick;
  logic        preset_load;
  logic [14:0] preset_phaseinc;
  logic [8:0]  preset_gain;
  logic        upd_ready;
  logic [14:0] phaseinc;
  logic [8:0]  gain;
  logic        upd_valid, busy, overrun;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [23:0] exp_q[$];

  param_update_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .enc_step(enc_step), .enc_dir(enc_dir), .enc_mode(enc_mode),
    .sweep_en(sweep_en), .sweep_tick(sweep_tick),
    .preset_load(preset_load), .preset_phaseinc(preset_phaseinc), .preset_gain(preset_gain),
    .upd_ready(upd_ready),
    .phaseinc(phaseinc), .gain(gain), .upd_valid(upd_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) tick();
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_offer(input logic [14:0] inc, input logic [8:0] g);
    exp_q.push_back({inc, g});
  endtask

  task automatic enc_pulse(input logic dir, input logic mode);
    enc_step = 1'b1; enc_dir = dir; enc_mode = mode;
    tick();
    enc_step = 1'b0;
  endtask

  task automatic preset_pulse(input logic [14:0] inc, input logic [8:0] g);
    preset_load = 1'b1; preset_phaseinc = inc; preset_gain = g;
    tick();
    preset_load = 1'b0;
  endtask

  task automatic sweep_pulse;
    sweep_tick = 1'b1;
    tick();
    sweep_tick = 1'b0;
  endtask

  // directed request with its hand-computed resulting offer
  task automatic do_enc(input logic dir, input logic mode, input logic [14:0] ei, input logic [8:0] eg);
    expect_offer(ei, eg);
    enc_pulse(dir, mode);
    settle(5);
  endtask

  task automatic do_preset(input logic [14:0] pi, input logic [8:0] pg, input logic [14:0] ei, input logic [8:0] eg);
    expect_offer(ei, eg);
    preset_pulse(pi, pg);
    settle(5);
  endtask

  task automatic do_sweep(input logic [14:0] ei, input logic [8:0] eg);
    expect_offer(ei, eg);
    sweep_pulse();
    settle(5);
  endtask

  // Monitor: every rising upd_valid is one offer to compare against the queue
  initial begin
    logic        prev;
    logic [23:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n && upd_valid && !prev) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_offer: got phaseinc=%0d gain=%0d, no offer expected", phaseinc, gain);
        end else begin
          e = exp_q.pop_front();
          if ({phaseinc, gain} !== e) begin
            n_fail++;
            $display("FAIL offer: got phaseinc=%0d gain=%0d expected phaseinc=%0d gain=%0d",
                     phaseinc, gain, e[23:9], e[8:0]);
          end
        end
      end
      prev = upd_valid;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    reset_n = 1'b0;
    enc_step = 1'b0; enc_dir = 1'b0; enc_mode = 1'b0;
    sweep_en = 1'b0; sweep_tick = 1'b0;
    preset_load = 1'b0; preset_phaseinc = '0; preset_gain = '0;
    upd_ready = 1'b1;
    settle(3);
    check("rst_phaseinc", int'(phaseinc), 1048);
    check("rst_gain", int'(gain), 32);
    check("rst_upd_valid", int'(upd_valid), 0);
    check("rst_busy", int'(busy), 0);
    reset_n = 1'b1;
    settle(2);
    check("rst_overrun", int'(overrun), 0);

    // 1: single encoder step, two-cycle latency
    expect_offer(15'd1049, 9'd32);
    enc_pulse(1'b1, 1'b0);
    check("t1_busy_apply", int'(busy), 1);
    tick();
    check("t1_phaseinc_n2", int'(phaseinc), 1049);
    check("t1_valid_n2", int'(upd_valid), 1);
    tick();
    check("t1_valid_drop", int'(upd_valid), 0);
    check("t1_busy_idle", int'(busy), 0);
    settle(3);

    // 2: preset clamp, then simultaneous enc + sweep served in priority order
    sweep_en = 1'b1;
    expect_offer(15'd20971, 9'd255);
    expect_offer(15'd20971, 9'd255);
    expect_offer(15'd21, 9'd255);
    preset_pulse(15'd30000, 9'd400);
    enc_step = 1'b1; enc_dir = 1'b1; enc_mode = 1'b0; sweep_tick = 1'b1;
    tick();
    enc_step = 1'b0; sweep_tick = 1'b0;
    settle(12);
    check("t2_phaseinc", int'(phaseinc), 21);

    // 3: saturation boundaries and sweep edge cases
    do_enc(1'b0, 1'b0, 15'd21, 9'd255);
    do_preset(15'd5, 9'd0, 15'd21, 9'd0);
    do_enc(1'b0, 1'b1, 15'd21, 9'd0);
    do_enc(1'b1, 1'b1, 15'd21, 9'd1);
    do_sweep(15'd85, 9'd1);
    do_preset(15'd20971, 9'd255, 15'd20971, 9'd255);
    do_enc(1'b1, 1'b1, 15'd20971, 9'd255);
    do_enc(1'b0, 1'b0, 15'd20970, 9'd255);
    do_preset(15'd20907, 9'd10, 15'd20907, 9'd10);
    do_sweep(15'd20971, 9'd10);
    do_sweep(15'd21, 9'd10);
    sweep_en = 1'b0;
    sweep_pulse();
    settle(5);
    check("t3_sweep_disabled_busy", int'(busy), 0);
    check("t3_sweep_disabled_inc", int'(phaseinc), 21);
    sweep_en = 1'b1;
    check("t3_overrun_clear", int'(overrun), 0);

    // 4: stalled offer, one pending step, one dropped, timeout then serve
    upd_ready = 1'b0;
    expect_offer(15'd22, 9'd10);
    enc_pulse(1'b1, 1'b0);
    tick();
    hi = 0;
    for (int i = 0; i < 60000; i++) begin
      if (!upd_valid) break;
      hi++;
      if (hi == 3) expect_offer(15'd23, 9'd10);
      enc_step = (hi == 3) || (hi == 4);
      enc_dir  = (hi == 3);
      enc_mode = 1'b0;
      tick();
    end
    enc_step = 1'b0;
    check("t4_timeout_cycles", hi, 50000);
    check("t4_overrun", int'(overrun), 1);
    check("t4_outputs_kept", int'(phaseinc), 22);
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      if (upd_valid) break;
      hi++;
      tick();
    end
    check("t4_pending_served_valid", int'(upd_valid), 1);
    check("t4_pending_phaseinc", int'(phaseinc), 23);
    upd_ready = 1'b1;
    settle(2);
    check("t4_valid_after_ready", int'(upd_valid), 0);
    settle(3);

    // 5: async reset during OFFER with all slots full
    upd_ready = 1'b0;
    expect_offer(15'd5000, 9'd100);
    preset_load = 1'b1; preset_phaseinc = 15'd5000; preset_gain = 9'd100;
    enc_step = 1'b1; enc_dir = 1'b1; enc_mode = 1'b1; sweep_tick = 1'b1;
    tick();
    preset_load = 1'b0; enc_step = 1'b0; sweep_tick = 1'b0;
    tick();
    preset_pulse(15'd6000, 9'd6);
    check("t5_in_offer", int'(upd_valid), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_rst_phaseinc", int'(phaseinc), 1048);
    check("t5_rst_gain", int'(gain), 32);
    check("t5_rst_valid", int'(upd_valid), 0);
    check("t5_rst_overrun", int'(overrun), 0);
    check("t5_rst_busy", int'(busy), 0);
    settle(2);
    reset_n = 1'b1;
    upd_ready = 1'b1;
    settle(10);
    check("t5_post_phaseinc", int'(phaseinc), 1048);
    check("t5_post_gain", int'(gain), 32);
    check("t5_post_busy", int'(busy), 0);

    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
